// File: rtl/valid_timer.sv
// -----------------------------------------------------------------------------
// valid_timer
//
// Generates a periodic one-clock step pulse for a downstream LED shifter.
// The raw switches are synchronised, then drive a two-state STOP/RUN FSM and
// a speed select that picks the period (R0..R3 clocks).
//
// Handshake: o_valid is a bare strobe with no ready. Each clock it is high
// marks exactly one step, and the consumer must accept it in that clock.
//
// Ports
//   clock      in   1  system clock, all state on its rising edge
//   i_reset    in   1  asynchronous active-low reset
//   i_sw       in   3  raw switches: [0] enable, [2:1] speed select
//   o_valid    out  1  registered one-clock step pulse
//   o_running  out  1  high while the FSM is in RUN (FSM state observation)
//   o_speed    out  2  currently applied (synchronised) speed select
// -----------------------------------------------------------------------------
module valid_timer #(
  parameter int              NB_COUNTER = 32,
  parameter longint unsigned R0         = 2**23,
  parameter longint unsigned R1         = 2**24,
  parameter longint unsigned R2         = 2**25,
  parameter longint unsigned R3         = 2**26
) (
  input  logic       clock,
  input  logic       i_reset,
  input  logic [2:0] i_sw,
  output logic       o_valid,
  output logic       o_running,
  output logic [1:0] o_speed
);

  typedef enum logic {
    ST_STOP = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // Terminal counts held as LIMIT-1 in counter width. A LIMIT of
  // 2**NB_COUNTER becomes all-ones, so the counter uses its full range.
  localparam logic [NB_COUNTER-1:0] LIM0_M1 = NB_COUNTER'(R0 - 64'd1);
  localparam logic [NB_COUNTER-1:0] LIM1_M1 = NB_COUNTER'(R1 - 64'd1);
  localparam logic [NB_COUNTER-1:0] LIM2_M1 = NB_COUNTER'(R2 - 64'd1);
  localparam logic [NB_COUNTER-1:0] LIM3_M1 = NB_COUNTER'(R3 - 64'd1);

  logic [2:0]            sw_meta_q, sw_meta_d;
  logic [2:0]            sw_sync_q, sw_sync_d;
  state_e                state_q, state_d;
  logic [NB_COUNTER-1:0] cnt_q, cnt_d;
  logic                  valid_q, valid_d;
  logic                  running_q, running_d;
  logic [1:0]            speed_q, speed_d;

  logic                  sync_en;
  logic [1:0]            sync_speed;
  logic                  speed_change;
  logic                  at_wrap;
  logic [NB_COUNTER-1:0] limit_m1;

  // Two-flop synchroniser on the raw switches.
  always_comb begin
    sw_meta_d = i_sw;
    sw_sync_d = sw_meta_q;
  end

  assign sync_en    = sw_sync_q[0];
  assign sync_speed = sw_sync_q[2:1];
  // speed_q holds the select applied last clock, so a difference means the
  // synchronised select has just moved.
  assign speed_change = (sync_speed != speed_q);

  always_comb begin
    limit_m1 = LIM0_M1;
    case (sync_speed)
      2'd0:    limit_m1 = LIM0_M1;
      2'd1:    limit_m1 = LIM1_M1;
      2'd2:    limit_m1 = LIM2_M1;
      2'd3:    limit_m1 = LIM3_M1;
      default: limit_m1 = LIM0_M1;
    endcase
  end

  assign at_wrap = (cnt_q == limit_m1);

  // Next-state, counter and output logic.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    valid_d   = 1'b0;
    running_d = 1'b0;
    speed_d   = sync_speed;

    case (state_q)
      ST_STOP: if (sync_en)  state_d = ST_RUN;
      ST_RUN:  if (!sync_en) state_d = ST_STOP;
      default: state_d = ST_STOP;
    endcase

    if (speed_change) begin
      // A new period starts cleanly: clear in any state, and this takes
      // precedence over a coincident wrap, so no pulse is produced.
      cnt_d = '0;
    end else if (state_q == ST_RUN) begin
      if (at_wrap) begin
        cnt_d = '0;
        // Suppress the pulse on the clock the FSM leaves RUN so o_valid is
        // never seen high while stopped.
        valid_d = (state_d == ST_RUN);
      end else begin
        cnt_d = cnt_q + NB_COUNTER'(1);
      end
    end
    // In STOP the count is held so RUN resumes mid-period.

    running_d = (state_d == ST_RUN);
  end

  always_ff @(posedge clock or negedge i_reset) begin
    if (!i_reset) begin
      sw_meta_q <= '0;
      sw_sync_q <= '0;
      state_q   <= ST_STOP;
      cnt_q     <= '0;
      valid_q   <= 1'b0;
      running_q <= 1'b0;
      speed_q   <= '0;
    end else begin
      sw_meta_q <= sw_meta_d;
      sw_sync_q <= sw_sync_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      valid_q   <= valid_d;
      running_q <= running_d;
      speed_q   <= speed_d;
    end
  end

  assign o_valid   = valid_q;
  assign o_running = running_q;
  assign o_speed   = speed_q;

endmodule

// File: doc/valid_timer.md
VALID_TIMER -- requirements
Module: valid_timer

Interface
REQ-001 SHALL have parameter NB_COUNTER, default 32, width of the period counter.
REQ-002 SHALL have parameter R0, default 2**23, period in clocks for speed select 0.
REQ-003 SHALL have parameter R1, default 2**24, period in clocks for speed select 1.
REQ-004 SHALL have parameter R2, default 2**25, period in clocks for speed select 2.
REQ-005 SHALL have parameter R3, default 2**26, period in clocks for speed select 3.
REQ-006 SHALL have port clock  input  1  single system clock; all state on its rising edge.
REQ-007 SHALL have port i_reset  input  1  asynchronous, active-low reset.
REQ-008 SHALL have port i_sw  input  3  raw switches: [0] enable, [2:1] speed select.
REQ-009 SHALL have port o_valid  output  1  one-clock step pulse to the downstream LED shifter.
REQ-010 SHALL have port o_running  output  1  high while the FSM is in RUN.
REQ-011 SHALL have port o_speed  output  2  currently applied speed select.

Function
REQ-012 SHALL pass i_sw through a 2-flop synchronizer; internal use sees switches 2 clocks late.
REQ-013 SHALL have FSM states STOP and RUN; STOP->RUN when synced enable=1, RUN->STOP when synced enable=0.
REQ-014 SHALL select LIMIT = R0..R3 by synced speed select; o_speed = registered synced select.
REQ-015 SHALL, in RUN, increment the counter each clock; at count == LIMIT-1 wrap to 0 and assert o_valid the next clock.
REQ-016 SHALL make o_valid exactly one clock wide, registered; period between pulses = LIMIT clocks.
REQ-017 SHALL hold the counter value in STOP (pause, not clear); RUN resumes from the held count.
REQ-018 SHALL never assert o_valid in STOP, including the clock the FSM leaves RUN.
REQ-019 SHALL, on any change of synced speed select, clear the counter to 0 in that clock with no pulse, regardless of state.
REQ-020 SHALL give speed change priority over wrap when both occur in the same clock (clear, no pulse).
REQ-021 SHALL, for LIMIT == 1, pulse o_valid every clock in RUN.
REQ-022 SHALL compare against LIMIT-1 using NB_COUNTER-bit unsigned arithmetic; LIMIT values must be 1..2**NB_COUNTER.
REQ-023 SHALL drive o_running = 1 exactly in RUN, registered with the state.

Reset
REQ-024 SHALL, on i_reset=0, immediately set state STOP, counter 0, synchronizer flops 0, o_valid 0, o_running 0, o_speed 0.
REQ-025 SHALL resume on the first rising clock edge after i_reset returns to 1; reset mid-period discards the partial count.
REQ-026 SHALL not emit a pulse in the first clock after reset release.

Verification (bench uses NB_COUNTER=8, R0=4, R1=8, R2=16, R3=1)
REQ-027 SHALL check: reset, i_sw=3'b001 held -> o_running rises 3 clocks later, o_valid pulses 1 clock wide every 4 clocks.
REQ-028 SHALL check: running at speed 0, switch to i_sw=3'b011 -> counter cleared, no pulse, next pulse 8 clocks after applied change, then every 8.
REQ-029 SHALL check: running speed 1, enable dropped at count 5, held 20 clocks, re-enabled -> no pulses while stopped, first pulse 3 clocks into RUN.
REQ-030 SHALL check: i_sw=3'b111 (R3=1) -> o_valid high every clock in RUN; drop enable -> o_valid low same clock as o_running falls.
REQ-031 SHALL check: i_reset pulled low asynchronously mid-period -> all outputs 0 without a clock edge; after release with enable high, first pulse a full period after RUN entry.
REQ-032 SHALL check: speed change landing on the wrap clock -> no pulse, count 0, next pulse a full new period later.
